oam_scan_unit: RTL and testbench
================================

// Module: oam_scan_unit
// PURPOSE
// - PPU mode-2 OAM scan engine. Reads the 40 OAM entries that OAM DMA fills, using the PPU-side OAM read port.
// - Selects up to 10 sprites whose Y range covers the current LY. Entries are taken in OAM order.
// - Holds the selected entries in a line sprite buffer for the pixel fetcher, which is downstream.
// - Scan timing is fixed: 2 cycles per entry (Y byte, then X byte), 80 request cycles per line.
// PARAMETERS
// - NUM_ENTRIES  40  OAM entries scanned per line
// - MAX_HITS     10  sprite buffer depth (per-line sprite limit)
// PORTS
// - clk           in   1  system clock
// - reset         in   1  synchronous, active-high reset
// - start         in   1  one-cycle pulse at mode-2 entry; begins a scan
// - ly            in   8  current line, sampled on the start cycle
// - obj_size      in   1  LCDC.2; 0 = 8 px tall, 1 = 16 px tall; sampled on start
// - dma_active    in   1  OAM DMA in progress; OAM data is invalid while high
// - oam_addr      out  8  OAM byte offset (0..159)
// - oam_read_en   out  1  read request; data returns one cycle later
// - oam_rdata     in   8  OAM read data, valid the cycle after oam_read_en
// - busy          out  1  high while a scan is in progress
// - done          out  1  one-cycle pulse when the scan completes
// - hit_count     out  4  number of valid buffer entries (0..10)
// - buf_rd_idx    in   4  sprite buffer read index
// - buf_y         out  8  Y byte of entry buf_rd_idx (combinational read)
// - buf_x         out  8  X byte of entry buf_rd_idx
// - buf_oam_idx   out  6  OAM entry number of entry buf_rd_idx (0..39)
// BEHAVIOUR
// - Reset values: state IDLE; busy=0; done=0; oam_read_en=0; oam_addr=0; hit_count=0.
// - Buffer contents are don't-care after reset.
// - States and transitions:
//   - IDLE -> SCAN on start.
//   - SCAN -> DRAIN after the request for entry 39's X byte.
//   - DRAIN -> DONE.
//   - DONE -> IDLE.
// - Start (edge E0): latch ly and obj_size, clear hit_count, set entry counter k=0, enter SCAN.
// - SCAN issues one request per cycle, for cycles 1..80 after start:
//   - Cycle 2k+1: oam_addr = 4k (Y byte).
//   - Cycle 2k+2: oam_addr = 4k+1 (X byte).
//   - oam_read_en is high on every SCAN cycle.
// - Y data arrives on cycle 2k+2 and is held in a register. X data arrives on cycle 2k+3.
// - Hit evaluation happens on the X-data cycle. Entry k is written to buf[hit_count] if both:
//   - the entry hits, and
//   - hit_count < MAX_HITS.
//   On a write, hit_count increments.
// - Hit test uses 9-bit arithmetic, h = obj_size ? 16 : 8:
//   - hit = (ly+16 >= y) && (ly+16 < y+h).
//   - X is not tested. X=0 entries still consume a slot.
// - DRAIN is cycle 81: it evaluates entry 39. oam_read_en=0. busy=1.
// - DONE is cycle 82: done=1 and busy=0.
// - The total scan is fixed at 82 cycles from start, regardless of hits or buffer full.
// - Buffer full: once hit_count=10, later hits are dropped. Scanning and timing are unchanged.
// - dma_active: any byte returned while dma_active=1 is treated as 8'hFF.
//   - A Y of FF never hits for ly <= 153.
//   - So an entry read during DMA is never selected.
// - start while busy: aborts and restarts from entry 0, with hit_count cleared.
//   - No done pulse is produced for the aborted scan.
//   - A pending returned byte from the aborted scan is discarded.
// - start in the DONE cycle: done still pulses, and the new scan starts as normal.
// - Reset mid-scan: returns to the reset values on the next edge. oam_read_en drops immediately.
// - hit_count and the buffer remain valid and stable from done until the next start.
// STRUCTURE
// - ppu_pkg (shared):
//   - OAM_ENTRIES = 40, MAX_SPRITES_PER_LINE = 10, OAM_ENTRY_BYTES = 4.
//   - scan_state_t {IDLE, SCAN, DRAIN, DONE}.
//   - sprite_entry_t struct {y[8], x[8], oam_idx[6]}.
// - One sub-module, line_sprite_buffer:
//   - MAX_HITS x sprite_entry_t register file.
//   - Write port: we, waddr, wdata. Asynchronous read port. hit_count is kept in the parent.
// TESTING
// 1. OAM all zero except entry 5 = {y=16, x=8}, ly=0, 8-px mode, start -> hit_count=1, buf[0]={16, 8, idx 5}, done exactly 82 cycles after start.
// 2. Entries 0..11 with y=30, ly=20 -> hit_count=10, buf[i].oam_idx=i for i=0..9; entries 10 and 11 dropped; done still at cycle 82.
// 3. Entry 0 y=20, 8-px: ly=11 -> hit; ly=12 -> miss. 16-px: ly=19 -> hit; ly=20 -> miss.
// 4. dma_active held high for the whole scan with 12 hitting entries in OAM -> hit_count=0, done at cycle 82.
// 5. start re-pulsed at cycle 40 -> exactly one done, 82 cycles after the second start; buffer reflects only the second scan.
// 6. reset asserted at cycle 30 -> next cycle busy=0, oam_read_en=0, hit_count=0; no done pulse follows.
// - Bench checks oam_addr and oam_read_en against the expected sequence on every cycle.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants used by the mode-2 OAM scan engine and its sprite buffer.
package ppu_pkg;

  localparam int OAM_ENTRIES          = 40;
  localparam int MAX_SPRITES_PER_LINE = 10;
  localparam int OAM_ENTRY_BYTES      = 4;
  localparam int SPRITE_ENTRY_W       = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [5:0] oam_idx;
  } sprite_entry_t;

  // OAM Y is stored as screen line + 16, so compare in 9 bits to avoid wrap.
  function automatic logic sprite_hits(input logic [7:0] ly, input logic [7:0] y,
                                       input logic tall);
    logic [8:0] line9;
    logic [8:0] top9;
    logic [8:0] bottom9;
    line9   = {1'b0, ly} + 9'd16;
    top9    = {1'b0, y};
    bottom9 = top9 + (tall ? 9'd16 : 9'd8);
    return (line9 >= top9) && (line9 < bottom9);
  endfunction

endpackage

// File: rtl/line_sprite_buffer.sv
// Per-line sprite register file: one write port, asynchronous read port.
module line_sprite_buffer
  import ppu_pkg::*;
#(
  parameter int MAX_HITS = MAX_SPRITES_PER_LINE
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [3:0]                waddr_i,
  input  logic [SPRITE_ENTRY_W-1:0] wdata_i,
  input  logic [3:0]                raddr_i,
  output logic [SPRITE_ENTRY_W-1:0] rdata_o
);

  localparam logic [3:0] DEPTH = 4'(MAX_HITS);

  sprite_entry_t mem_q [MAX_HITS];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < DEPTH)) begin
      mem_q[waddr_i] <= sprite_entry_t'(wdata_i);
    end
  end

  always_comb begin
    rdata_o = '0;
    if (raddr_i < DEPTH) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/oam_scan_unit.sv
// PPU mode-2 OAM scan: walks all OAM entries at 2 cycles each and keeps up to
// MAX_HITS sprites covering the latched line in the line sprite buffer.
module oam_scan_unit
  import ppu_pkg::*;
#(
  parameter int NUM_ENTRIES = OAM_ENTRIES,
  parameter int MAX_HITS    = MAX_SPRITES_PER_LINE
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] ly_i,
  input  logic       obj_size_i,
  input  logic       dma_active_i,
  output logic [7:0] oam_addr_o,
  output logic       oam_read_en_o,
  input  logic [7:0] oam_rdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] hit_count_o,
  input  logic [3:0] buf_rd_idx_i,
  output logic [7:0] buf_y_o,
  output logic [7:0] buf_x_o,
  output logic [5:0] buf_oam_idx_o
);

  localparam logic [6:0] LAST_REQ  = 7'(2 * NUM_ENTRIES - 1);
  localparam logic [3:0] HIT_LIMIT = 4'(MAX_HITS);

  scan_state_t state_q, state_d;
  logic [6:0]  reqCnt_q, reqCnt_d;
  logic [3:0]  hitCount_q, hitCount_d;
  logic [7:0]  ly_q;
  logic        objSize_q;
  logic [7:0]  yByte_q;
  logic        rdValid_q;
  logic        rdIsX_q;
  logic [5:0]  rdEntry_q;

  logic [7:0]  rdByte;
  logic        bufWe;
  sprite_entry_t wrEntry;
  sprite_entry_t rdEntry;
  logic [SPRITE_ENTRY_W-1:0] rdEntryBits;

  always_comb begin
    state_d  = state_q;
    reqCnt_d = reqCnt_q;
    case (state_q)
      IDLE: ;
      SCAN: begin
        reqCnt_d = reqCnt_q + 7'd1;
        if (reqCnt_q == LAST_REQ) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A start pulse always wins, aborting any scan in flight.
    if (start_i) begin
      state_d  = SCAN;
      reqCnt_d = '0;
    end
  end

  // Request address is entry*4 plus 0 for the Y byte or 1 for the X byte.
  assign oam_read_en_o = (state_q == SCAN) && !reset_i;
  assign oam_addr_o    = (state_q == SCAN) ? {reqCnt_q[6:1], 1'b0, reqCnt_q[0]} : 8'd0;
  assign busy_o        = (state_q == SCAN) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);
  assign hit_count_o   = hitCount_q;

  assign rdByte = dma_active_i ? 8'hFF : oam_rdata_i;

  always_comb begin
    wrEntry.y       = yByte_q;
    wrEntry.x       = rdByte;
    wrEntry.oam_idx = rdEntry_q;
    bufWe = rdValid_q && rdIsX_q && !start_i && (hitCount_q < HIT_LIMIT)
            && sprite_hits(ly_q, yByte_q, objSize_q);
    hitCount_d = hitCount_q;
    if (start_i) begin
      hitCount_d = '0;
    end else if (bufWe) begin
      hitCount_d = hitCount_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      reqCnt_q   <= '0;
      hitCount_q <= '0;
      rdValid_q  <= 1'b0;
      rdIsX_q    <= 1'b0;
      rdEntry_q  <= '0;
      ly_q       <= '0;
      objSize_q  <= 1'b0;
      yByte_q    <= '0;
    end else begin
      state_q    <= state_d;
      reqCnt_q   <= reqCnt_d;
      hitCount_q <= hitCount_d;
      rdValid_q  <= (state_q == SCAN) && !start_i;
      rdIsX_q    <= reqCnt_q[0];
      rdEntry_q  <= reqCnt_q[6:1];
      if (start_i) begin
        ly_q      <= ly_i;
        objSize_q <= obj_size_i;
      end
      if (rdValid_q && !rdIsX_q) begin
        yByte_q <= rdByte;
      end
    end
  end

  line_sprite_buffer #(
    .MAX_HITS(MAX_HITS)
  ) u_buffer (
    .clk_i  (clk_i),
    .we_i   (bufWe),
    .waddr_i(hitCount_q),
    .wdata_i(wrEntry),
    .raddr_i(buf_rd_idx_i),
    .rdata_o(rdEntryBits)
  );

  assign rdEntry       = sprite_entry_t'(rdEntryBits);
  assign buf_y_o       = rdEntry.y;
  assign buf_x_o       = rdEntry.x;
  assign buf_oam_idx_o = rdEntry.oam_idx;

endmodule

// File: tb/tb_oam_scan_unit.sv
// Directed bench for oam_scan_unit with a registered OAM model and per-cycle request checks.
module tb_oam_scan_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ly;
  logic       objSize;
  logic       dmaActive;
  logic [7:0] oamAddr;
  logic       oamReadEn;
  logic [7:0] oamRdata;
  logic       busy;
  logic       done;
  logic [3:0] hitCount;
  logic [3:0] bufRdIdx;
  logic [7:0] bufY;
  logic [7:0] bufX;
  logic [5:0] bufOamIdx;

  logic [7:0] oamMem [160];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oam_scan_unit dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .ly_i         (ly),
    .obj_size_i   (objSize),
    .dma_active_i (dmaActive),
    .oam_addr_o   (oamAddr),
    .oam_read_en_o(oamReadEn),
    .oam_rdata_i  (oamRdata),
    .busy_o       (busy),
    .done_o       (done),
    .hit_count_o  (hitCount),
    .buf_rd_idx_i (bufRdIdx),
    .buf_y_o      (bufY),
    .buf_x_o      (bufX),
    .buf_oam_idx_o(bufOamIdx)
  );

  // OAM read port: data returns on the cycle after the request.
  always @(posedge clk) begin
    if (oamReadEn && (oamAddr < 8'd160)) oamRdata <= oamMem[oamAddr];
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearOam();
    for (int i = 0; i < 160; i++) oamMem[i] = 8'h00;
  endtask

  task automatic setEntry(input int idx, input logic [7:0] yVal, input logic [7:0] xVal);
    oamMem[idx*4]   = yVal;
    oamMem[idx*4+1] = xVal;
  endtask

  task automatic applyStimulus(input logic [7:0] lyVal, input logic sizeVal, input logic dmaVal);
    @(negedge clk);
    ly        = lyVal;
    objSize   = sizeVal;
    dmaActive = dmaVal;
    start     = 1'b1;
  endtask

  // Runs from the cycle after a start pulse; checks request/status outputs every cycle.
  task automatic scanCycles(input int restartAt, input logic [7:0] restartLy,
                            input int resetAt, input int expDones);
    int base = 0;
    int lastCyc = 90;
    int cyc = 0;
    int rel;
    int dones = 0;
    bit inReset = 0;
    logic expRd, expBusy, expDone;
    logic [7:0] expAddr;
    while (cyc < lastCyc) begin
      cyc++;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      rel = cyc - base;
      expRd   = !inReset && (rel >= 1) && (rel <= 80);
      expBusy = !inReset && (rel >= 1) && (rel <= 81);
      expDone = !inReset && (rel == 82);
      expAddr = 8'(((rel - 1) / 2) * 4 + ((rel - 1) % 2));
      checkOutput($sformatf("readEn@%0d", cyc), oamReadEn, expRd);
      checkOutput($sformatf("busy@%0d", cyc), busy, expBusy);
      checkOutput($sformatf("done@%0d", cyc), done, expDone);
      if (expRd) checkOutput($sformatf("addr@%0d", cyc), oamAddr, expAddr);
      if (done) dones++;
      if (inReset && (cyc == resetAt + 1)) checkOutput("hitCountAfterReset", hitCount, 0);
      if (cyc == restartAt) begin
        start   = 1'b1;
        ly      = restartLy;
        base    = cyc;
        lastCyc = cyc + 90;
      end
      if (cyc == resetAt) begin
        reset   = 1'b1;
        inReset = 1;
        #1 checkOutput("readEnDropsOnReset", oamReadEn, 0);
      end
    end
    checkOutput("doneCount", dones, expDones);
  endtask

  task automatic checkBuffer(input int idx, input logic [7:0] yVal, input logic [7:0] xVal,
                             input int oamIdx);
    bufRdIdx = 4'(idx);
    #1;
    checkOutput($sformatf("bufY[%0d]", idx), bufY, yVal);
    checkOutput($sformatf("bufX[%0d]", idx), bufX, xVal);
    checkOutput($sformatf("bufIdx[%0d]", idx), bufOamIdx, oamIdx);
  endtask

  typedef struct {
    logic [7:0] ly;
    logic       objSize;
    int         oamIdx;
    logic [7:0] yVal;
    logic [7:0] xVal;
    int         expCount;
  } hitVec_t;

  hitVec_t vecs [9];

  initial begin
    vecs[0] = '{8'd0,   1'b0, 5,  8'd16,  8'd8,    1};
    vecs[1] = '{8'd11,  1'b0, 0,  8'd20,  8'd33,   1};
    vecs[2] = '{8'd12,  1'b0, 0,  8'd20,  8'd33,   0};
    vecs[3] = '{8'd19,  1'b1, 0,  8'd20,  8'd44,   1};
    vecs[4] = '{8'd20,  1'b1, 0,  8'd20,  8'd44,   0};
    vecs[5] = '{8'd84,  1'b0, 39, 8'd100, 8'd0,    1};
    vecs[6] = '{8'd4,   1'b1, 20, 8'd16,  8'hA0,   1};
    vecs[7] = '{8'd0,   1'b0, 7,  8'd9,   8'd1,    1};
    vecs[8] = '{8'd0,   1'b0, 7,  8'd8,   8'd1,    0};

    reset = 1'b1; start = 1'b0; ly = '0; objSize = 1'b0; dmaActive = 1'b0; bufRdIdx = '0;
    clearOam();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetReadEn", oamReadEn, 0);
    checkOutput("resetAddr", oamAddr, 0);
    checkOutput("resetHitCount", hitCount, 0);

    // Single-entry hit window vectors.
    for (int v = 0; v < 9; v++) begin
      clearOam();
      setEntry(vecs[v].oamIdx, vecs[v].yVal, vecs[v].xVal);
      applyStimulus(vecs[v].ly, vecs[v].objSize, 1'b0);
      scanCycles(-1, 8'd0, -1, 1);
      checkOutput($sformatf("vec%0d hitCount", v), hitCount, vecs[v].expCount);
      if (vecs[v].expCount == 1) checkBuffer(0, vecs[v].yVal, vecs[v].xVal, vecs[v].oamIdx);
    end

    // Twelve hitting entries: buffer fills at ten, later hits dropped.
    clearOam();
    for (int i = 0; i < 12; i++) setEntry(i, 8'd30, 8'(i + 1));
    applyStimulus(8'd20, 1'b0, 1'b0);
    scanCycles(-1, 8'd0, -1, 1);
    checkOutput("fullHitCount", hitCount, 10);
    for (int i = 0; i < 10; i++) checkBuffer(i, 8'd30, 8'(i + 1), i);

    // Same OAM read entirely during DMA: nothing may be selected.
    applyStimulus(8'd20, 1'b0, 1'b1);
    scanCycles(-1, 8'd0, -1, 1);
    checkOutput("dmaHitCount", hitCount, 0);
    dmaActive = 1'b0;

    // Restart mid-scan with a new line; entry 19's pending X byte must be discarded.
    clearOam();
    for (int i = 0; i < 4; i++) setEntry(i, 8'd30, 8'(i + 1));
    for (int i = 4; i < 7; i++) setEntry(i, 8'd60, 8'(i + 16));
    setEntry(19, 8'd60, 8'h77);
    applyStimulus(8'd20, 1'b0, 1'b0);
    scanCycles(40, 8'd50, -1, 1);
    checkOutput("restartHitCount", hitCount, 4);
    checkBuffer(0, 8'd60, 8'd20, 4);
    checkBuffer(1, 8'd60, 8'd21, 5);
    checkBuffer(2, 8'd60, 8'd22, 6);
    checkBuffer(3, 8'd60, 8'h77, 19);

    // Reset in the middle of a scan with hits already recorded.
    applyStimulus(8'd20, 1'b0, 1'b0);
    scanCycles(-1, 8'd0, 30, 0);
    checkOutput("postResetHitCount", hitCount, 0);

    // Start on the DONE cycle: done still pulses and the new scan clears the count.
    applyStimulus(8'd20, 1'b0, 1'b0);
    scanCycles(82, 8'd100, -1, 2);
    checkOutput("startInDoneHitCount", hitCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
